// File: rtl/div_sched_pkg.sv
// Shared types for the two-requester divider scheduler.
package div_sched_pkg;

  localparam int unsigned NREQ = 2;

  typedef logic [$clog2(NREQ)-1:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping around.
module rr_arbiter
  import div_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_id_t         ptr,
  output logic [NREQ-1:0] grant,
  output req_id_t         grant_id
);

  logic        found;
  int unsigned idx;

  // Scan from the favoured requester; the first hit wins.
  always_comb begin
    grant    = '0;
    grant_id = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = req_id_t'(idx);
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Two-requester unsigned divider: round-robin request acceptance, restoring
// shift-subtract division (one quotient bit per cycle, MSB first) and a
// response held until the addressed requester consumes it.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] dividend0,
  input  logic [N-1:0] dividend1,
  input  logic [N-1:0] divisor0,
  input  logic [N-1:0] divisor1,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         Z,
  output logic         neg,
  output logic         dz_err
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t         state_q, state_d;
  req_id_t        ptr_q, ptr_d;
  req_id_t        id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   work_q, work_d;   // dividend shifting out, quotient bits shifting in
  logic [N:0]     rem_q, rem_d;     // partial remainder
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rout_q, rout_d;
  logic           dz_q, dz_d;

  logic [NREQ-1:0] grant;
  req_id_t         grant_id;
  logic [N-1:0]    sel_dividend, sel_divisor;
  logic [N:0]      shifted, rem_next;
  logic            qbit;

  rr_arbiter u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Operand mux and one restoring-division step.
  always_comb begin
    sel_dividend = (grant_id == req_id_t'(1)) ? dividend1 : dividend0;
    sel_divisor  = (grant_id == req_id_t'(1)) ? divisor1  : divisor0;
    shifted      = {rem_q[N-1:0], work_q[N-1]};
    qbit         = (shifted >= {1'b0, dvs_q});
    rem_next     = qbit ? (shifted - {1'b0, dvs_q}) : shifted;
  end

  // FSM next state, datapath next state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    rout_d     = rout_q;
    dz_d       = dz_q;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          id_d  = grant_id;
          ptr_d = (grant_id == req_id_t'(NREQ - 1)) ? '0 : grant_id + req_id_t'(1);
          if (sel_divisor == '0) begin
            // Divide by zero short-circuits straight to a result.
            state_d = DONE;
            quot_d  = '0;
            rout_d  = '0;
            dz_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = DIV;
            work_d  = sel_dividend;
            rem_d   = '0;
            dvs_d   = sel_divisor;
            cnt_d   = CW'(N);
          end
        end
      end
      DIV: begin
        work_d = {work_q[N-2:0], qbit};
        rem_d  = rem_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = {work_q[N-2:0], qbit};
          rout_d  = rem_next[N-1:0];  // remainder < divisor, so the top bit is 0
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        resp_valid[id_q] = 1'b1;
        if (resp_ready[id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rout_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rout_q  <= rout_d;
      dz_q    <= dz_d;
    end
  end

  // Result outputs and flags derived from the registered quotient.
  always_comb begin
    quotient  = quot_q;
    remainder = rout_q;
    dz_err    = dz_q;
    Z         = (quot_q == '0);
    neg       = quot_q[N-1];
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: directed vectors plus randomized requests checked
// against an arithmetic reference model with a round-robin pointer.
module tb_div_scheduler;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0] dividend0, dividend1, divisor0, divisor1;
  logic [N-1:0] quotient, remainder;
  logic         Z, neg, dz_err;

  int errors = 0;
  int checks = 0;

  // Reference state: favoured requester and last delivered result.
  int           ptr;
  logic [N-1:0] last_q, last_r;
  logic         last_dz;

  div_scheduler #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .dividend0  (dividend0),
    .dividend1  (dividend1),
    .divisor0   (divisor0),
    .divisor1   (divisor1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .Z          (Z),
    .neg        (neg),
    .dz_err     (dz_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_quotient"}, 32'(quotient), 0);
    check({tag, "_remainder"}, 32'(remainder), 0);
    check({tag, "_Z"}, 32'(Z), 1);
    check({tag, "_neg"}, 32'(neg), 0);
    check({tag, "_dz_err"}, 32'(dz_err), 0);
  endtask

  // One request/response transaction. Called just after a falling edge with
  // the DUT idle; returns just after a falling edge with the DUT idle again.
  task automatic run_txn(input logic [1:0] rv, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input logic [N-1:0] a1, input logic [N-1:0] b1, input int hold);
    int           id, lat;
    logic [1:0]   oh;
    logic [N-1:0] a, b, eq, er;
    logic         edz;
    req_valid = rv;
    dividend0 = a0;
    divisor0  = b0;
    dividend1 = a1;
    divisor1  = b1;
    #1;
    id = rv[ptr] ? ptr : 1 - ptr;
    oh = 2'(1 << id);
    check("req_ready", 32'(req_ready), 32'(oh));
    a = (id == 1) ? a1 : a0;
    b = (id == 1) ? b1 : b0;
    if (b == 0) begin
      eq = '0; er = '0; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
    @(posedge clk);
    ptr = 1 - id;
    #1;
    // Requests arriving while busy must be ignored.
    req_valid = 2'($urandom_range(0, 3));
    dividend0 = N'($urandom);
    dividend1 = N'($urandom);
    divisor0  = N'($urandom);
    divisor1  = N'($urandom);
    lat = 0;
    @(negedge clk);
    while (resp_valid == 2'b00 && lat < 4 * N) begin
      check("busy_req_ready", 32'(req_ready), 0);
      check("busy_hold_q", 32'(quotient), 32'(last_q));
      check("busy_hold_r", 32'(remainder), 32'(last_r));
      @(negedge clk);
      lat++;
    end
    // Result is visible in the cycle after the N-th DIV edge, or in the cycle
    // right after the accepting edge for a zero divisor.
    check("latency", 32'(lat), edz ? 0 : N);
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("Z", 32'(Z), 32'(eq == 0));
    check("neg", 32'(neg), 32'(eq[N-1]));
    check("dz_err", 32'(dz_err), 32'(edz));
    for (int h = 0; h < hold; h++) begin
      resp_ready = ~oh;  // only the other requester acknowledges
      @(negedge clk);
      check("hold_resp_valid", 32'(resp_valid), 32'(oh));
      check("hold_quotient", 32'(quotient), 32'(eq));
      check("hold_remainder", 32'(remainder), 32'(er));
      check("hold_flags", 32'({Z, neg, dz_err}), 32'({eq == 0, eq[N-1], edz}));
      check("hold_req_ready", 32'(req_ready), 0);
    end
    resp_ready = oh;
    @(posedge clk);
    #1;
    resp_ready = 2'b00;
    req_valid  = 2'b00;
    @(negedge clk);
    check("resp_drop", 32'(resp_valid), 0);
    check("idle_keep_q", 32'(quotient), 32'(eq));
    last_q  = eq;
    last_r  = er;
    last_dz = edz;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    dividend0  = '0;
    dividend1  = '0;
    divisor0   = '0;
    divisor1   = '0;
    ptr        = 0;
    last_q     = '0;
    last_r     = '0;
    last_dz    = 1'b0;
    #2;
    check_reset_outputs("reset");
    check("reset_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Both requesters always valid: service must alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      run_txn(2'b11, N'($urandom), N'($urandom_range(1, 255)),
              N'($urandom), N'($urandom_range(1, 255)), 0);
    end

    // Directed vectors.
    run_txn(2'b01, 100, 7, 0, 0, 1);
    run_txn(2'b10, 0, 0, 5, 9, 0);
    run_txn(2'b01, 200, 1, 0, 0, 2);
    run_txn(2'b01, 37, 0, 0, 0, 5);

    // Randomized traffic, including zero and unit divisors.
    for (int k = 0; k < 30; k++) begin
      logic [N-1:0] b0, b1;
      int sel;
      sel = $urandom_range(0, 9);
      b0 = (sel == 0) ? '0 : (sel == 1) ? N'(1) : N'($urandom_range(1, 255));
      sel = $urandom_range(0, 9);
      b1 = (sel == 0) ? '0 : (sel == 1) ? N'(1) : N'($urandom_range(1, 255));
      run_txn(2'($urandom_range(1, 3)), N'($urandom), b0, N'($urandom), b1,
              $urandom_range(0, 3));
    end

    // Reset in the middle of a division aborts it without a response.
    req_valid = 2'b10;
    dividend1 = 100;
    divisor1  = 7;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'(ptr == 1 || ptr == 0 ? 2'b10 : 2'b00));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    check("abort_req_ready_idle", 32'(req_ready), 0);
    @(negedge clk);
    rst     = 1'b0;
    ptr     = 0;
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    #1;
    check("abort_no_resp", 32'(resp_valid), 0);
    // Pointer favours requester 0 again, and work resumes normally.
    run_txn(2'b11, 100, 7, 5, 9, 0);
    run_txn(2'b11, 100, 7, 5, 9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
